prog_clk_divider: RTL
=====================

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels.
REQ-002 Parameter CNT_W, default 32: width of per-channel counter and half-period value.
REQ-003 Parameter SLOW_HALF, default 2500000: reset value of every channel's programmed half-period terminal count.
REQ-004 Parameter FAST_HALF, default 30: fixed terminal count used in FAST and STEP modes.
REQ-005 Port clk_in, input, 1: the single system clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port cfg_valid, input, 1: config request valid.
REQ-008 Port cfg_ready, output, 1: the addressed channel can accept a config.
REQ-009 Port cfg_ch, input, $clog2(NUM_CH) (min 1): target channel.
REQ-010 Port cfg_mode, input, 2: 00 HOLD, 01 SLOW, 10 FAST, 11 STEP.
REQ-011 Port cfg_half, input, CNT_W: new programmed terminal count for SLOW mode.
REQ-012 Port step_req, input, NUM_CH: per-channel single-period request.
REQ-013 Port clk_out, output, NUM_CH: divided clocks.
REQ-014 Port tick, output, NUM_CH: one-cycle pulse coincident with each 0->1 transition of clk_out.
REQ-015 Port busy, output, NUM_CH: channel has a pending config or an active step.

Function
REQ-016 Each channel SHALL count 0..T and toggle clk_out when cnt>=T, clearing cnt in the same cycle; the half-period is T+1 cycles.
REQ-017 T SHALL equal the active programmed half in SLOW and FAST_HALF in FAST/STEP.
REQ-018 HOLD SHALL freeze clk_out at its current level and hold cnt at 0.
REQ-019 A config transfer SHALL occur when cfg_valid && cfg_ready; cfg_ready = !pending[cfg_ch].
REQ-020 A transferred config SHALL go to a per-channel shadow register and set pending; it SHALL NOT affect the running count.
REQ-021 Pending config SHALL be applied in the cycle clk_out toggles, or in the cycle after transfer if the channel is in HOLD or idle in STEP; cnt restarts at 0 and pending clears.
REQ-022 Entering HOLD or STEP from SLOW/FAST by config SHALL take effect only at a toggle that leaves clk_out=0; a toggle to 1 defers the application by one half-period.
REQ-023 In STEP, idle with clk_out=0: step_req[ch]=1 SHALL produce exactly one high half and one low half of FAST_HALF+1 cycles each, then return to idle.
REQ-024 step_req during an active step or in non-STEP modes SHALL be ignored.
REQ-025 A transfer targeting a channel with pending=1 SHALL NOT occur (cfg_ready=0); the held request completes when pending clears.
REQ-026 cfg_half=0 SHALL yield toggling every cycle (clk_in/2); no lower bound check.
REQ-027 The counter SHALL NOT wrap; cnt>=T comparison SHALL cover a T reduced below the current cnt.
REQ-028 tick[ch] SHALL be registered, asserted exactly one cycle, in the cycle after clk_out rises.
REQ-029 busy[ch] SHALL equal pending[ch] OR step active.

Reset
REQ-030 On rst_n=0, all channels SHALL immediately take: mode SLOW, programmed half SLOW_HALF, cnt 0, clk_out 0, tick 0, pending 0, step inactive.
REQ-031 cfg_ready SHALL read 1 during and after reset.
REQ-032 Reset mid-step or mid-pending SHALL discard the step/config without any output glitch beyond the forced 0.
REQ-033 Reset release SHALL be honoured on the next rising edge of clk_in; first toggle occurs SLOW_HALF+1 cycles later.

Structure
REQ-034 Shared package clk_div_pkg SHALL hold the 2-bit mode encoding constants and the SLOW_HALF/FAST_HALF defaults.
REQ-035 One channel sub-module clk_div_chan (counter, shadow, step FSM IDLE/HIGH/LOW) SHALL be instantiated NUM_CH times; top holds cfg decode and ready mux.

Verification (NUM_CH=2, CNT_W=8, SLOW_HALF=4, FAST_HALF=1)
REQ-036 Reset release -> ch0 clk_out rises at cycle 5, period 10 cycles, tick pulses once per period.
REQ-037 Config ch1 FAST mid-half-period -> old period finishes, then clk_out period 4 cycles; pending/busy clear at the toggle.
REQ-038 Config ch0 SLOW half=2 then immediate second config -> cfg_ready=0 until first applies; second applies at following toggle.
REQ-039 Config ch0 STEP, pulse step_req twice 1 cycle apart -> exactly one high of 2 cycles, low of 2 cycles, then idle at 0.
REQ-040 Config HOLD while clk_out=1 -> channel continues to next 0 toggle then freezes at 0.
REQ-041 Assert rst_n=0 mid-step -> clk_out=0, busy=0 immediately, no tick.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared definitions for the programmable clock divider:
//               2-bit channel mode encoding, step-sequencer state encoding,
//               default half-period terminal counts and a small mode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  // Channel operating mode as carried on cfg_mode.
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;  // clk_out frozen, counter parked at 0
  localparam mode_t MODE_SLOW = 2'b01;  // terminal count = programmed half
  localparam mode_t MODE_FAST = 2'b10;  // terminal count = FAST_HALF
  localparam mode_t MODE_STEP = 2'b11;  // single periods on step request

  // Single-step sequencer states.
  typedef logic [1:0] step_st_t;

  localparam step_st_t ST_IDLE = 2'd0;  // waiting for a step request, clk_out=0
  localparam step_st_t ST_HIGH = 2'd1;  // first (high) half of the step period
  localparam step_st_t ST_LOW  = 2'd2;  // second (low) half of the step period

  // Default terminal counts; a half-period lasts terminal count + 1 cycles.
  localparam int DEF_SLOW_HALF = 2500000;
  localparam int DEF_FAST_HALF = 30;

  // SLOW and FAST run the free-running divider; HOLD and STEP do not.
  function automatic logic is_run_mode(input mode_t m);
    return (m == MODE_SLOW) || (m == MODE_FAST);
  endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel. Free-running half-period counter with a
//               shadowed configuration that is only applied at safe points,
//               plus a single-step sequencer (IDLE/HIGH/LOW) for STEP mode.
// Ports       : clk_i       - system clock, rising edge
//               rst_ni      - asynchronous active-low reset
//               cfg_we_i    - accepted config for this channel (one cycle)
//               cfg_mode_i  - mode carried by the accepted config
//               cfg_half_i  - programmed half terminal count for SLOW mode
//               step_req_i  - single-period request (STEP mode, idle only)
//               clk_o       - divided clock
//               tick_o      - one-cycle pulse in the first cycle clk_o is high
//               busy_o      - config pending or step in progress
//               pend_o      - config held in the shadow register
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int SLOW_HALF = DEF_SLOW_HALF,
  parameter int FAST_HALF = DEF_FAST_HALF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  mode_t            cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_half_i,
  input  logic             step_req_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] c_slow_half = CNT_W'(SLOW_HALF);
  localparam logic [CNT_W-1:0] c_fast_half = CNT_W'(FAST_HALF);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  // Active configuration and counter.
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  // Shadow configuration waiting for its application point.
  logic             pend_q, pend_d;
  mode_t            sh_mode_q, sh_mode_d;
  logic [CNT_W-1:0] sh_half_q, sh_half_d;

  // Single-step sequencer.
  step_st_t         st_q, st_d;

  logic [CNT_W-1:0] w_term;
  logic             w_hit;
  logic             w_apply;

  // Terminal count for the running half-period.
  assign w_term = (mode_q == MODE_SLOW) ? half_q : c_fast_half;

  // Magnitude compare rather than equality: a terminal count reprogrammed
  // below the current count still terminates the half-period at once.
  assign w_hit = (cnt_q >= w_term);

  always_comb begin
    mode_d    = mode_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    pend_d    = pend_q;
    sh_mode_d = sh_mode_q;
    sh_half_d = sh_half_q;
    st_d      = st_q;
    w_apply   = 1'b0;

    case (mode_q)
      MODE_HOLD: begin
        cnt_d   = '0;
        w_apply = pend_q;
      end

      MODE_SLOW, MODE_FAST: begin
        if (w_hit) begin
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
          cnt_d  = '0;
          // Leaving the free-running modes must park clk_out low, so HOLD
          // or STEP waits for the toggle that drives the output to 0.
          w_apply = pend_q && (is_run_mode(sh_mode_q) || clk_q);
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      default: begin  // MODE_STEP
        case (st_q)
          ST_HIGH: begin
            if (w_hit) begin
              clk_d = 1'b0;
              cnt_d = '0;
              st_d  = ST_LOW;
            end else begin
              cnt_d = cnt_q + c_cnt_one;
            end
          end

          ST_LOW: begin
            if (w_hit) begin
              cnt_d = '0;
              st_d  = ST_IDLE;
            end else begin
              cnt_d = cnt_q + c_cnt_one;
            end
          end

          default: begin  // ST_IDLE
            cnt_d = '0;
            // A waiting config is serviced before any new step begins.
            if (pend_q) begin
              w_apply = 1'b1;
            end else if (step_req_i && !clk_q) begin
              st_d   = ST_HIGH;
              clk_d  = 1'b1;
              tick_d = 1'b1;
            end
          end
        endcase
      end
    endcase

    if (w_apply) begin
      mode_d = sh_mode_q;
      half_d = sh_half_q;
      cnt_d  = '0;
      pend_d = 1'b0;
      st_d   = ST_IDLE;
    end

    // The top only asserts cfg_we_i while pend_q is clear, so a new config
    // and an application never collide in the same cycle.
    if (cfg_we_i) begin
      sh_mode_d = cfg_mode_i;
      sh_half_d = cfg_half_i;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= MODE_SLOW;
      half_q    <= c_slow_half;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      sh_mode_q <= MODE_SLOW;
      sh_half_q <= c_slow_half;
      st_q      <= ST_IDLE;
    end else begin
      mode_q    <= mode_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      sh_mode_q <= sh_mode_d;
      sh_half_q <= sh_half_d;
      st_q      <= st_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;
  assign busy_o = pend_q || (st_q != ST_IDLE);

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module      : prog_clk_divider
// Description : Multi-channel programmable clock divider. Decodes the shared
//               config request onto one channel, returns that channel's
//               ready, and instantiates NUM_CH independent divider channels.
// Ports       : clk_in     - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               cfg_valid  - config request valid
//               cfg_ready  - addressed channel can accept a config
//               cfg_ch     - target channel
//               cfg_mode   - 00 HOLD, 01 SLOW, 10 FAST, 11 STEP
//               cfg_half   - programmed half terminal count for SLOW mode
//               step_req   - per-channel single-period request
//               clk_out    - divided clocks
//               tick       - one-cycle pulse as each clk_out goes high
//               busy       - per-channel pending config or active step
// Revision    : 1.0 - initial release
// ============================================================================
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 32,
  parameter int SLOW_HALF = DEF_SLOW_HALF,
  parameter int FAST_HALF = DEF_FAST_HALF,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] step_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_we;

  // Ready mirrors the addressed channel's free shadow slot. A channel index
  // beyond NUM_CH reads ready and is dropped, so a stray request never stalls
  // the config port.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !w_pend[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_we[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

      clk_div_chan #(
        .CNT_W     (CNT_W),
        .SLOW_HALF (SLOW_HALF),
        .FAST_HALF (FAST_HALF)
      ) u_chan (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .cfg_we_i   (w_we[g]),
        .cfg_mode_i (cfg_mode),
        .cfg_half_i (cfg_half),
        .step_req_i (step_req[g]),
        .clk_o      (clk_out[g]),
        .tick_o     (tick[g]),
        .busy_o     (busy[g]),
        .pend_o     (w_pend[g])
      );
    end
  endgenerate

endmodule : prog_clk_divider
`default_nettype wire
